temp_sample_buffer: RTL
=======================

TEMP_SAMPLE_BUFFER -- requirements
Module: temp_sample_buffer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, sample FIFO entries (power of two).
REQ-002 SHALL have parameter AVG_LEN_LOG2, default 3, log2 of the moving-average window (8 samples).
REQ-003 SHALL have port clk, input, 1: single clock, the I2C FSM clock domain; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port byte_valid, input, 1: one-cycle strobe from the I2C FSM per received ADT7420 data byte.
REQ-006 SHALL have port byte_data, input, 8: received byte, qualified by byte_valid.
REQ-007 SHALL have port ack_err, input, 1: one-cycle NACK/abort strobe from the I2C FSM.
REQ-008 SHALL have port clear, input, 1: host flush strobe (from Opal Kelly trigger wire).
REQ-009 SHALL have port rd_en, input, 1: host pop request.
REQ-010 SHALL have port temp_raw, output, 13: latest sample, signed, 0.0625 degC/LSB.
REQ-011 SHALL have port temp_avg, output, 13: signed moving average.
REQ-012 SHALL have port avg_valid, output, 1: window filled.
REQ-013 SHALL have port sample_valid, output, 1: one-cycle pulse per committed sample.
REQ-014 SHALL have port fifo_dout, output, 16: popped entry, sign-extended temp_raw.
REQ-015 SHALL have port rd_valid, output, 1: fifo_dout valid.
REQ-016 SHALL have ports fifo_empty, output, 1; fifo_full, output, 1; fifo_count, output, log2(FIFO_DEPTH)+1.
REQ-017 SHALL have port overflow, output, 1: sticky, sample dropped on full.

Function
REQ-018 Assembly FSM SHALL have states WAIT_MSB, WAIT_LSB.
- WAIT_MSB + byte_valid: latch MSB, go to WAIT_LSB.
- WAIT_LSB + byte_valid: commit {MSB, LSB[7:3]}, return to WAIT_MSB.
REQ-019 ack_err in WAIT_LSB SHALL discard the latched MSB and return to WAIT_MSB; in WAIT_MSB it has no effect.
REQ-020 ack_err and byte_valid in the same cycle: ack_err SHALL win and the byte is discarded.
REQ-021 Commit SHALL, on the cycle after the LSB strobe:
- update temp_raw;
- pulse sample_valid;
- push the sample into the window and the FIFO.
REQ-022 Window SHALL be a 2^AVG_LEN_LOG2 shift register with a running signed 16-bit sum (add new, subtract evicted).
REQ-023 temp_avg SHALL equal sum arithmetic-shifted right by AVG_LEN_LOG2, registered, valid one cycle after sample_valid.
REQ-024 avg_valid SHALL assert once 2^AVG_LEN_LOG2 samples have been committed since reset/clear; earlier averages include zero entries.
REQ-025 Push when full and no pop: sample SHALL be dropped and overflow set; temp_raw and the window still update.
REQ-026 Pop with rd_en:
- when not empty: fifo_dout and rd_valid SHALL follow on the next cycle.
- when empty: no pop, rd_valid stays low, count unchanged.
REQ-027 Simultaneous push and pop SHALL both occur, including when full (count unchanged, no overflow) and when empty (pop ignored, push occurs).
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL range 0..FIFO_DEPTH.
REQ-029 clear SHALL, with priority over a same-cycle push or pop:
- empty the FIFO;
- zero the window, sum, temp_avg and avg_valid;
- clear overflow;
- return the FSM to WAIT_MSB.
temp_raw SHALL be kept.

Reset
REQ-030 rst_n low SHALL immediately force:
- FSM to WAIT_MSB;
- all outputs to 0, except fifo_empty=1;
- pointers, window and sum to 0.
REQ-031 Reset mid-sample SHALL discard the partial MSB; the first byte after release is treated as MSB.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, TEMP_W=13 and the degC LSB scale constant.
REQ-033 The FIFO SHALL be one sub-module, sync_fifo, parameterised in width and depth.

Verification
REQ-034 MSB 0x0C, LSB 0x80 SHALL give temp_raw=0x190 (400, 25.0 degC), sample_valid pulse, fifo_count=1.
REQ-035 MSB 0xFF, LSB 0x80 SHALL give temp_raw=0x1FF0 (-16, -1.0 degC) and fifo_dout=0xFFF0 on pop.
REQ-036 Eight samples of 400 SHALL give avg_valid=1 and temp_avg=400; a ninth sample of -16 SHALL give temp_avg=348.
REQ-037 Seventeen samples with no pops SHALL give fifo_full=1 and overflow=1; a pop then SHALL return the first sample.
REQ-038 MSB, then ack_err, then 0x0C, 0x80 SHALL commit exactly one sample of 400.
REQ-039 clear asserted with a same-cycle LSB commit SHALL give fifo_empty=1, avg_valid=0, overflow=0.

Source files
------------

// File: rtl/temp_sample_buffer_pkg.sv
// Shared types and constants for the ADT7420 sample buffer.
// Temperature samples are 13-bit two's complement at 1/16 degC per LSB.
package temp_sample_buffer_pkg;

    localparam int TEMP_W       = 13;
    localparam int SUM_W        = 16;
    localparam int FIFO_W       = 16;
    // One LSB is 1/DEGC_LSB_DIV degC (0.0625 degC).
    localparam int DEGC_LSB_DIV = 16;

    typedef enum logic {
        WAIT_MSB = 1'b0,
        WAIT_LSB = 1'b1
    } asm_state_e;

    function automatic logic [FIFO_W-1:0] sext_fifo(input logic [TEMP_W-1:0] t);
        return {{(FIFO_W-TEMP_W){t[TEMP_W-1]}}, t};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, clear, and sticky drop flag.
// A pop frees a slot in the same cycle, so push+pop while full is accepted.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             rd_valid_q, rd_valid_d;
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop     = pop && (count_q != '0) && !clr;
        do_push    = push && !clr && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dout_d     = dout_q;
        rd_valid_d = do_pop;
        ovf_d      = ovf_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                dout_d   = mem_q[rd_ptr_q];
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (push && !do_push) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign dout     = dout_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign overflow = ovf_q;

endmodule

// File: rtl/temp_sample_buffer.sv
// Assembles ADT7420 MSB/LSB byte pairs into 13-bit samples, keeps a running
// moving average over a 2^AVG_LEN_LOG2 window, and queues samples for the host.
module temp_sample_buffer
    import temp_sample_buffer_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int AVG_LEN_LOG2 = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_data,
    input  logic                          ack_err,
    input  logic                          clear,
    input  logic                          rd_en,
    output logic [TEMP_W-1:0]             temp_raw,
    output logic [TEMP_W-1:0]             temp_avg,
    output logic                          avg_valid,
    output logic                          sample_valid,
    output logic [FIFO_W-1:0]             fifo_dout,
    output logic                          rd_valid,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AVG_N = 1 << AVG_LEN_LOG2;
    localparam int FW    = AVG_LEN_LOG2 + 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(AVG_N);

    asm_state_e                     state_q, state_d;
    logic [7:0]                     msb_q, msb_d;
    logic [TEMP_W-1:0]              temp_raw_q, temp_raw_d;
    logic                           sample_valid_q, sample_valid_d;
    logic [AVG_N-1:0][TEMP_W-1:0]   win_q, win_d;
    logic signed [SUM_W-1:0]        sum_q, sum_d;
    logic [FW-1:0]                  fill_q, fill_d;
    logic [TEMP_W-1:0]              temp_avg_q, temp_avg_d;
    logic                           avg_valid_q, avg_valid_d;

    logic                           commit;
    logic [TEMP_W-1:0]              sample;
    logic [FIFO_W-1:0]              fifo_din;
    logic signed [SUM_W-1:0]        sample_sx, evict_sx, sum_shift;
    logic                           unused_flags;

    // Low three LSB bits are ADT7420 status flags in 13-bit mode.
    assign unused_flags = ^byte_data[2:0];
    assign sample       = {msb_q, byte_data[7:3]};
    assign fifo_din     = sext_fifo(sample);
    assign sample_sx    = $signed(SUM_W'(sext_fifo(sample)));
    assign evict_sx     = $signed(SUM_W'(sext_fifo(win_q[AVG_N-1])));
    assign sum_shift    = sum_q >>> AVG_LEN_LOG2;

    always_comb begin
        state_d        = state_q;
        msb_d          = msb_q;
        commit         = 1'b0;
        temp_raw_d     = temp_raw_q;
        sample_valid_d = 1'b0;
        win_d          = win_q;
        sum_d          = sum_q;
        fill_d         = fill_q;
        // Average lags the sum by one register stage.
        temp_avg_d     = sum_shift[TEMP_W-1:0];
        avg_valid_d    = (fill_q == FILL_MAX);

        if (clear) begin
            state_d = WAIT_MSB;
        end else if (ack_err) begin
            state_d = WAIT_MSB;
        end else if (byte_valid) begin
            case (state_q)
                WAIT_MSB: begin
                    msb_d   = byte_data;
                    state_d = WAIT_LSB;
                end
                WAIT_LSB: begin
                    commit  = 1'b1;
                    state_d = WAIT_MSB;
                end
                default: state_d = WAIT_MSB;
            endcase
        end

        if (clear) begin
            win_d       = '0;
            sum_d       = '0;
            fill_d      = '0;
            temp_avg_d  = '0;
            avg_valid_d = 1'b0;
        end else if (commit) begin
            temp_raw_d     = sample;
            sample_valid_d = 1'b1;
            win_d          = {win_q[AVG_N-2:0], sample};
            sum_d          = sum_q + sample_sx - evict_sx;
            fill_d         = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= WAIT_MSB;
            msb_q          <= '0;
            temp_raw_q     <= '0;
            sample_valid_q <= 1'b0;
            win_q          <= '0;
            sum_q          <= '0;
            fill_q         <= '0;
            temp_avg_q     <= '0;
            avg_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            msb_q          <= msb_d;
            temp_raw_q     <= temp_raw_d;
            sample_valid_q <= sample_valid_d;
            win_q          <= win_d;
            sum_q          <= sum_d;
            fill_q         <= fill_d;
            temp_avg_q     <= temp_avg_d;
            avg_valid_q    <= avg_valid_d;
        end
    end

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clear),
        .push     (commit),
        .din      (fifo_din),
        .pop      (rd_en),
        .dout     (fifo_dout),
        .rd_valid (rd_valid),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count),
        .overflow (overflow)
    );

    assign temp_raw     = temp_raw_q;
    assign temp_avg     = temp_avg_q;
    assign avg_valid    = avg_valid_q;
    assign sample_valid = sample_valid_q;

endmodule
